// File: rtl/gene_attractor_det_if.sv
// Bus between the gene-network sampler and the attractor detector.
//
// Handshake: start and x_valid are single-cycle qualifiers sampled on the
// rising edge of clk. There is no ready: the detector accepts every x_valid
// it sees while tracking and silently ignores samples otherwise. done is a
// one-cycle pulse. found/fixed_pt/period/transient/attr_state are valid from
// that pulse until the next start or reset.
interface gene_attractor_det_if #(
  parameter int W     = 8,
  parameter int CNT_W = 5
);
  logic             start;
  logic [W-1:0]     x_in;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             found;
  logic             fixed_pt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] transient;
  logic [W-1:0]     attr_state;

  modport master (
    output start, x_in, x_valid,
    input  busy, done, found, fixed_pt, period, transient, attr_state
  );

  modport slave (
    input  start, x_in, x_valid,
    output busy, done, found, fixed_pt, period, transient, attr_state
  );
endinterface

// File: rtl/gene_attractor_det.sv
// Attractor detector for the gene network state trajectory. Stores each new
// state in a small history, compares every incoming sample against all stored
// entries in parallel and stops at the first repeat, reporting period,
// transient length, the repeated state and whether it is a fixed point.
// A trajectory longer than DEPTH distinct states reports a timeout.
module gene_attractor_det #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gene_attractor_det_if.slave    bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     hist_q [DEPTH];
  logic             hist_we;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             fixed_q, fixed_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] trans_q, trans_d;
  logic [W-1:0]     attr_q, attr_d;

  logic             match_hit;
  logic [CNT_W-1:0] match_idx;

  // Parallel compare of the sample against valid history; lowest index wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && (hist_q[i] == bus.x_in)) begin
        match_hit = 1'b1;
        match_idx = CNT_W'(i);
      end
    end
  end

  // Next-state and next-output logic; start overrides everything, including
  // a coincident x_valid.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    vld_d    = vld_q;
    hist_we  = 1'b0;
    found_d  = found_q;
    fixed_d  = fixed_q;
    period_d = period_q;
    trans_d  = trans_q;
    attr_d   = attr_q;

    if (bus.start) begin
      state_d  = TRACK;
      wr_ptr_d = '0;
      vld_d    = '0;
      found_d  = 1'b0;
      fixed_d  = 1'b0;
      period_d = '0;
      trans_d  = '0;
      attr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        TRACK: begin
          if (bus.x_valid) begin
            if (match_hit) begin
              found_d  = 1'b1;
              period_d = wr_ptr_q - match_idx;
              fixed_d  = ((wr_ptr_q - match_idx) == ONE_C);
              trans_d  = match_idx;
              attr_d   = bus.x_in;
              state_d  = DONE;
            end else if (wr_ptr_q < DEPTH_C) begin
              hist_we  = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE_C;
              for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr_q == CNT_W'(i)) begin
                  vld_d[i] = 1'b1;
                end
              end
            end else begin
              // History full with no repeat: report a timeout.
              found_d  = 1'b0;
              fixed_d  = 1'b0;
              period_d = '0;
              trans_d  = '0;
              attr_d   = '0;
              state_d  = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == TRACK);
    done_d = (state_d == DONE);
  end

  // State, pointer, valid bits and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      vld_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      fixed_q  <= 1'b0;
      period_q <= '0;
      trans_q  <= '0;
      attr_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      fixed_q  <= fixed_d;
      period_q <= period_d;
      trans_q  <= trans_d;
      attr_q   <= attr_d;
    end
  end

  // History storage; contents are qualified by vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (hist_we && (wr_ptr_q == CNT_W'(i))) begin
        hist_q[i] <= bus.x_in;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.found      = found_q;
  assign bus.fixed_pt   = fixed_q;
  assign bus.period     = period_q;
  assign bus.transient  = trans_q;
  assign bus.attr_state = attr_q;
  assign dbg_state      = state_q;

endmodule
